// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS memory-access stage.
package mips_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam int          ACK_TIMEOUT_DEFAULT = 16;
  localparam logic [31:0] WORD_ALIGN_MASK     = 32'h0000_0003;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM->WB pipeline register: loads the retiring instruction, inserts a bubble
// while the stage stalls, and converts an errored access into a killed write.
module mem_wb_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        err,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  input  logic [31:0] alu_out_in,
  input  logic [31:0] read_data_in,
  input  logic [4:0]  write_reg_in,
  output logic        reg_write_w,
  output logic        mem_to_reg_w,
  output logic [31:0] alu_out_w,
  output logic [31:0] read_data_w,
  output logic [4:0]  write_reg_w,
  output logic        mem_err_w
);

  logic        reg_write_d,  reg_write_q;
  logic        mem_to_reg_d, mem_to_reg_q;
  logic [31:0] alu_out_d,    alu_out_q;
  logic [31:0] read_data_d,  read_data_q;
  logic [4:0]  write_reg_d,  write_reg_q;
  logic        mem_err_d,    mem_err_q;

  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path can infer a latch.
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    mem_err_d    = 1'b0;
    alu_out_d    = alu_out_q;
    read_data_d  = read_data_q;
    write_reg_d  = write_reg_q;
    if (!stall) begin
      alu_out_d   = alu_out_in;
      read_data_d = read_data_in;
      write_reg_d = write_reg_in;
      if (err) begin
        mem_err_d = 1'b1;
      end else begin
        reg_write_d  = reg_write_in;
        mem_to_reg_d = mem_to_reg_in;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the register is small flops, so it is reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_out_q    <= '0;
      read_data_q  <= '0;
      write_reg_q  <= '0;
      mem_err_q    <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_out_q    <= alu_out_d;
      read_data_q  <= read_data_d;
      write_reg_q  <= write_reg_d;
      mem_err_q    <= mem_err_d;
    end
  end

  assign reg_write_w  = reg_write_q;
  assign mem_to_reg_w = mem_to_reg_q;
  assign alu_out_w    = alu_out_q;
  assign read_data_w  = read_data_q;
  assign write_reg_w  = write_reg_q;
  assign mem_err_w    = mem_err_q;

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: data-memory handshake FSM with ack timeout and MEM->WB register.
// Optional MEM_ALIGN_CHECK_EN rejects word-misaligned accesses without touching memory.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_write_m,
  input  logic        mem_to_reg_m,
  input  logic        mem_write_m,
  input  logic        branch_m,
  input  logic        zero_m,
  input  logic [31:0] alu_out_m,
  input  logic [31:0] write_data_m,
  input  logic [4:0]  write_reg_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_m,
  output logic        pc_src_m,
  output logic        reg_write_w,
  output logic        mem_to_reg_w,
  output logic [31:0] read_data_w,
  output logic [31:0] alu_out_w,
  output logic [4:0]  write_reg_w,
  output logic        mem_err_w
);

  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  mem_state_t  state_d, state_q;
  logic [7:0]  cnt_d, cnt_q;
  logic        access_pending, misaligned, mem_go, is_load, timeout, stall;
  logic [31:0] rdata_in;

  always_comb begin
    access_pending = mem_write_m | mem_to_reg_m;
`ifdef MEM_ALIGN_CHECK_EN
    misaligned = access_pending & (|(alu_out_m & WORD_ALIGN_MASK));
`else
    misaligned = 1'b0;
`endif
    mem_go   = access_pending & ~misaligned;
    is_load  = mem_go & mem_to_reg_m & ~mem_write_m;
    timeout  = (state_q == WAIT) && (cnt_q == CNT_LAST);
    stall    = mem_go & ~dmem_ack & ~timeout;
    rdata_in = (is_load && dmem_ack) ? dmem_rdata : 32'h0;

    // The counter holds the number of cycles the access has already waited,
    // so the IDLE cycle counts as the first one and timeout hits after ACK_TIMEOUT.
    state_d = state_q;
    cnt_d   = 8'd0;
    case (state_q)
      IDLE: begin
        if (stall) begin
          state_d = WAIT;
          cnt_d   = 8'd1;
        end
      end
      WAIT: begin
        if (!stall) state_d = IDLE;
        else        cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset gates the request so an abandoned access drops off the bus at once.
  assign dmem_req   = mem_go & ~reset;
  assign dmem_we    = mem_go & mem_write_m & ~reset;
  assign dmem_addr  = alu_out_m;
  assign dmem_wdata = write_data_m;
  assign stall_m    = stall & ~reset;
  assign pc_src_m   = branch_m & zero_m;

  mem_wb_reg u_mem_wb_reg (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .err          (timeout | misaligned),
    .reg_write_in (reg_write_m),
    .mem_to_reg_in(mem_to_reg_m),
    .alu_out_in   (alu_out_m),
    .read_data_in (rdata_in),
    .write_reg_in (write_reg_m),
    .reg_write_w  (reg_write_w),
    .mem_to_reg_w (mem_to_reg_w),
    .alu_out_w    (alu_out_w),
    .read_data_w  (read_data_w),
    .write_reg_w  (write_reg_w),
    .mem_err_w    (mem_err_w)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench: two instances (ACK_TIMEOUT 16 and 4) driven in lockstep,
// compared each cycle against a per-transaction reference model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write_m, mem_to_reg_m, mem_write_m, branch_m, zero_m;
  logic [31:0] alu_out_m, write_data_m, dmem_rdata;
  logic [4:0]  write_reg_m;
  logic        dmem_ack;

  logic        dmem_req [2];
  logic        dmem_we [2];
  logic [31:0] dmem_addr [2];
  logic [31:0] dmem_wdata [2];
  logic        stall_m [2];
  logic        pc_src_m [2];
  logic        reg_write_w [2];
  logic        mem_to_reg_w [2];
  logic [31:0] read_data_w [2];
  logic [31:0] alu_out_w [2];
  logic [4:0]  write_reg_w [2];
  logic        mem_err_w [2];

  int tests = 0;
  int fails = 0;
  int to_cyc [2];

  // Expected MEM->WB contents per instance
  logic        e_rw [2];
  logic        e_mtr [2];
  logic [31:0] e_alu [2];
  logic [31:0] e_rd [2];
  logic [4:0]  e_wr [2];
  logic        e_err [2];

  always #5 clk = ~clk;

  mem_access_stage #(.ACK_TIMEOUT(16)) u_dut16 (
    .clk(clk), .reset(reset),
    .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m), .mem_write_m(mem_write_m),
    .branch_m(branch_m), .zero_m(zero_m), .alu_out_m(alu_out_m),
    .write_data_m(write_data_m), .write_reg_m(write_reg_m),
    .dmem_req(dmem_req[0]), .dmem_we(dmem_we[0]), .dmem_addr(dmem_addr[0]),
    .dmem_wdata(dmem_wdata[0]), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_m(stall_m[0]), .pc_src_m(pc_src_m[0]),
    .reg_write_w(reg_write_w[0]), .mem_to_reg_w(mem_to_reg_w[0]),
    .read_data_w(read_data_w[0]), .alu_out_w(alu_out_w[0]),
    .write_reg_w(write_reg_w[0]), .mem_err_w(mem_err_w[0])
  );

  mem_access_stage #(.ACK_TIMEOUT(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m), .mem_write_m(mem_write_m),
    .branch_m(branch_m), .zero_m(zero_m), .alu_out_m(alu_out_m),
    .write_data_m(write_data_m), .write_reg_m(write_reg_m),
    .dmem_req(dmem_req[1]), .dmem_we(dmem_we[1]), .dmem_addr(dmem_addr[1]),
    .dmem_wdata(dmem_wdata[1]), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_m(stall_m[1]), .pc_src_m(pc_src_m[1]),
    .reg_write_w(reg_write_w[1]), .mem_to_reg_w(mem_to_reg_w[1]),
    .read_data_w(read_data_w[1]), .alu_out_w(alu_out_w[1]),
    .write_reg_w(write_reg_w[1]), .mem_err_w(mem_err_w[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_nop();
    reg_write_m = 0; mem_to_reg_m = 0; mem_write_m = 0; branch_m = 0; zero_m = 0;
    alu_out_m = 0; write_data_m = 0; write_reg_m = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      e_rw[i] = 0; e_mtr[i] = 0; e_alu[i] = 0; e_rd[i] = 0; e_wr[i] = 0; e_err[i] = 0;
    end
  endtask

  task automatic check_wb(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s[%0d].reg_write_w", tag, i), reg_write_w[i], e_rw[i]);
      check($sformatf("%s[%0d].mem_to_reg_w", tag, i), mem_to_reg_w[i], e_mtr[i]);
      check($sformatf("%s[%0d].alu_out_w", tag, i), alu_out_w[i], e_alu[i]);
      check($sformatf("%s[%0d].read_data_w", tag, i), read_data_w[i], e_rd[i]);
      check($sformatf("%s[%0d].write_reg_w", tag, i), write_reg_w[i], e_wr[i]);
      check($sformatf("%s[%0d].mem_err_w", tag, i), mem_err_w[i], e_err[i]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s[%0d].dmem_req", tag, i), dmem_req[i], 1'b0);
      check($sformatf("%s[%0d].stall_m", tag, i), stall_m[i], 1'b0);
    end
    model_clear();
    check_wb(tag);
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 with reset released.
  task automatic do_reset(input string tag);
    drive_nop();
    reset = 1;
    #2;
    check_reset_outputs(tag);
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
  endtask

  // One instruction in the MEM stage; d = cycles before ack (99 = never).
  task automatic run_txn(input string tag, input logic rw, input logic mtr, input logic mw,
                         input logic br, input logic z, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] rdv,
                         input logic [4:0] wr, input int d);
    logic pend, mis, go, ld, ack_k;
    logic st [2];
    int   ret [2];
    logic err [2];
    int   kmax;
    pend = mw | mtr;
    mis  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = pend && (alu[1:0] != 2'b00);
`endif
    go = pend && !mis;
    ld = go && mtr && !mw;
    for (int i = 0; i < 2; i++) begin
      if (!go)                     begin ret[i] = 0;            err[i] = mis;  end
      else if (d >= to_cyc[i] - 1) begin ret[i] = to_cyc[i] - 1; err[i] = 1'b1; end
      else                         begin ret[i] = d;            err[i] = 1'b0; end
    end
    kmax = go ? ((d < 3) ? d : 3) : 0;
    reg_write_m = rw; mem_to_reg_m = mtr; mem_write_m = mw; branch_m = br; zero_m = z;
    alu_out_m = alu; write_data_m = wd; write_reg_m = wr;
    for (int k = 0; k <= kmax; k++) begin
      ack_k      = go ? (k == d) : 1'($urandom_range(0, 1));
      dmem_ack   = ack_k;
      dmem_rdata = ack_k ? rdv : $urandom;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        st[i] = go && (k < ret[i]);
        check($sformatf("%s[%0d].k%0d.stall_m", tag, i, k), stall_m[i], st[i]);
        check($sformatf("%s[%0d].k%0d.dmem_req", tag, i, k), dmem_req[i], go);
        check($sformatf("%s[%0d].k%0d.dmem_we", tag, i, k), dmem_we[i], go && mw);
        check($sformatf("%s[%0d].k%0d.pc_src_m", tag, i, k), pc_src_m[i], br && z);
        if (go) begin
          check($sformatf("%s[%0d].k%0d.dmem_addr", tag, i, k), dmem_addr[i], alu);
          check($sformatf("%s[%0d].k%0d.dmem_wdata", tag, i, k), dmem_wdata[i], wd);
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (st[i]) begin
          e_rw[i] = 0; e_mtr[i] = 0; e_err[i] = 0;
        end else begin
          e_rw[i]  = err[i] ? 1'b0 : rw;
          e_mtr[i] = err[i] ? 1'b0 : mtr;
          e_err[i] = err[i];
          e_alu[i] = alu;
          e_wr[i]  = wr;
          e_rd[i]  = (ld && ack_k && !err[i]) ? rdv : 32'h0;
        end
      end
      check_wb($sformatf("%s.k%0d", tag, k));
    end
    drive_nop();
    // The long-timeout instance is still waiting on a never-acked access.
    if (go && d == 99) do_reset({tag, ".rst"});
  endtask

  initial begin
    int op, r, d;
    logic rw, mtr, mw;
    logic [31:0] alu;
    to_cyc[0] = 16;
    to_cyc[1] = 4;
    model_clear();
    do_reset("reset_state");

    run_txn("load_zero_wait", 1, 1, 0, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 5'd3, 0);
    run_txn("store_3_wait", 0, 0, 1, 0, 0, 32'h20, 32'h55, 32'h0, 5'd0, 3);
    run_txn("load_timeout", 1, 1, 0, 0, 0, 32'h80, 32'h0, 32'h0, 5'd4, 99);
    run_txn("branch_taken", 1, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0, 5'd0, 0);
    run_txn("load_misaligned", 1, 1, 0, 0, 0, 32'h102, 32'h0, 32'h1234_5678, 5'd7, 0);

    // Reset during the second WAIT cycle with the load still presented
    reg_write_m = 1; mem_to_reg_m = 1; mem_write_m = 0; branch_m = 0; zero_m = 0;
    alu_out_m = 32'h40; write_data_m = 0; write_reg_m = 5'd9; dmem_ack = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    #1;
    check_reset_outputs("mid_wait_reset");
    drive_nop();
    @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    run_txn("load_after_reset", 1, 1, 0, 0, 0, 32'h40, 32'h0, 32'hCAFE_F00D, 5'd9, 0);

    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      rw = 1'($urandom_range(0, 1));
      mtr = (op == 1) || (op == 3);
      mw  = (op == 2) || (op == 3);
      if (op == 1) rw = 1;
      alu = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) alu = alu | 32'($urandom_range(1, 3));
      r = $urandom_range(0, 4);
      d = (r == 4) ? 99 : r;
      if (mtr && !mw && d == 3) d = 2;
      run_txn($sformatf("rand%0d", n), rw, mtr, mw, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), alu, $urandom, $urandom,
              5'($urandom_range(0, 31)), d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
